// File: rtl/jesd_link_ctrl.sv
// JESD204 receive link bring-up / supervision FSM with retry, back-off and fault latch.
// Latency: every output is registered and moves one clk_i edge after the input that triggers it.
// Backpressure: none; inputs are sampled every cycle and the block never stalls.
//
// Ports: clk_i/resetn_i (async active-low); link_enable_i, clk_locked_i, lane_ready_i[NUM_LANES],
//        frame_align_err_i, lane_state_err_i, sysref_align_err_i, clear_fault_i in;
//        jesd_reset_o, link_up_o, fault_o, state_o[3], retry_cnt_o[8], err_cnt_o[16] out.
// Define JESD_LINK_CTRL_ERR_COUNT_EN to build the LINK_UP error counter; otherwise err_cnt_o is 0.
module jesd_link_ctrl #(
    parameter int NUM_LANES           = 3,
    parameter int LOCK_WAIT_CYCLES    = 1024,
    parameter int RESET_CYCLES        = 16,
    parameter int SYNC_TIMEOUT_CYCLES = 65536,
    parameter int BACKOFF_CYCLES      = 256,
    parameter int MAX_RETRIES         = 7
) (
    input  logic                 clk_i,
    input  logic                 resetn_i,
    input  logic                 link_enable_i,
    input  logic                 clk_locked_i,
    input  logic [NUM_LANES-1:0] lane_ready_i,
    input  logic                 frame_align_err_i,
    input  logic                 lane_state_err_i,
    input  logic                 sysref_align_err_i,
    input  logic                 clear_fault_i,
    output logic                 jesd_reset_o,
    output logic                 link_up_o,
    output logic                 fault_o,
    output logic [2:0]           state_o,
    output logic [7:0]           retry_cnt_o,
    output logic [15:0]          err_cnt_o
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_RESET     = 3'd2,
        ST_WAIT_SYNC = 3'd3,
        ST_LINK_UP   = 3'd4,
        ST_BACKOFF   = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    // One dwell counter serves every timed state, so it is sized for the longest wait.
    localparam int MAX_A = (LOCK_WAIT_CYCLES > RESET_CYCLES) ? LOCK_WAIT_CYCLES : RESET_CYCLES;
    localparam int MAX_B = (SYNC_TIMEOUT_CYCLES > BACKOFF_CYCLES) ? SYNC_TIMEOUT_CYCLES : BACKOFF_CYCLES;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] LOCK_LAST    = CW'(LOCK_WAIT_CYCLES - 1);
    localparam logic [CW-1:0] RESET_LAST   = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] SYNC_LAST    = CW'(SYNC_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] BACKOFF_LAST = CW'(BACKOFF_CYCLES - 1);
    localparam logic [7:0]    MAX_R        = 8'(MAX_RETRIES);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      retry_q, retry_d;
    logic            jesd_reset_q, jesd_reset_d;
    logic            link_up_q, link_up_d;
    logic            fault_q, fault_d;
    logic            all_ready, any_err, retry_inc;

    assign all_ready = &lane_ready_i;
    assign any_err   = frame_align_err_i | lane_state_err_i | sysref_align_err_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        retry_inc = 1'b0;

        if (state_q != ST_FAULT && !link_enable_i) begin
            state_d = ST_IDLE;
        end else if ((state_q inside {ST_RESET, ST_WAIT_SYNC, ST_LINK_UP, ST_BACKOFF}) && !clk_locked_i) begin
            // Lost lock is an infrastructure event, not a failed attempt.
            state_d = ST_WAIT_LOCK;
        end else begin
            case (state_q)
                ST_IDLE:      state_d = ST_WAIT_LOCK;
                ST_WAIT_LOCK: if (clk_locked_i && cnt_q == LOCK_LAST) state_d = ST_RESET;
                ST_RESET:     if (cnt_q == RESET_LAST) state_d = ST_WAIT_SYNC;
                ST_WAIT_SYNC: begin
                    // Ready wins over a coincident timeout.
                    if (all_ready) begin
                        state_d = ST_LINK_UP;
                    end else if (cnt_q == SYNC_LAST) begin
                        state_d   = ST_BACKOFF;
                        retry_inc = 1'b1;
                    end
                end
                ST_LINK_UP: begin
                    if (any_err || !all_ready) begin
                        state_d   = ST_BACKOFF;
                        retry_inc = 1'b1;
                    end
                end
                ST_BACKOFF: begin
                    if (cnt_q == BACKOFF_LAST) state_d = (retry_q >= MAX_R) ? ST_FAULT : ST_WAIT_LOCK;
                end
                ST_FAULT:     if (clear_fault_i) state_d = ST_IDLE;
                default:      state_d = ST_IDLE;
            endcase
        end

        // Dwell counter: restarts on any state change; WAIT_LOCK also restarts it while unlocked.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == ST_WAIT_LOCK && !clk_locked_i) begin
            cnt_d = '0;
        end else if (state_q inside {ST_WAIT_LOCK, ST_RESET, ST_WAIT_SYNC, ST_BACKOFF}) begin
            cnt_d = cnt_q + CW'(1);
        end

        if (state_d == ST_IDLE) begin
            retry_d = '0;
        end else if (retry_inc && retry_q != 8'hFF) begin
            retry_d = retry_q + 8'd1;
        end

        jesd_reset_d = !(state_d inside {ST_WAIT_SYNC, ST_LINK_UP});
        link_up_d    = (state_d == ST_LINK_UP);
        fault_d      = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            retry_q      <= '0;
            jesd_reset_q <= 1'b1;
            link_up_q    <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            jesd_reset_q <= jesd_reset_d;
            link_up_q    <= link_up_d;
            fault_q      <= fault_d;
        end
    end

`ifdef JESD_LINK_CTRL_ERR_COUNT_EN
    logic [15:0] err_q, err_d;

    // clear_fault beats a coincident error; simultaneous error inputs count once.
    always_comb begin
        err_d = err_q;
        if (clear_fault_i) begin
            err_d = '0;
        end else if (state_q == ST_LINK_UP && any_err && err_q != 16'hFFFF) begin
            err_d = err_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_cnt_o = err_q;
`else
    assign err_cnt_o = '0;
`endif

    assign state_o      = state_q;
    assign retry_cnt_o  = retry_q;
    assign jesd_reset_o = jesd_reset_q;
    assign link_up_o    = link_up_q;
    assign fault_o      = fault_q;

endmodule
